// File: rtl/vxe_intr_sched.sv
// Interrupt event scheduler: round-robin intake from NR_SRC producers, hold-off coalescing, one merged pulse to vxe_intr_unit.
// Optional event counters are enabled by defining VXE_INTR_SCHED_STATS_EN.
module vxe_intr_sched #(
    parameter int NR_SRC    = 4,
    parameter int NR_INT    = 4,
    parameter int HOLDOFF_W = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [NR_SRC-1:0]        i_src_vld,
    input  logic [NR_SRC*NR_INT-1:0] i_src_intr,
    output logic [NR_SRC-1:0]        o_src_rdy,
    input  logic [HOLDOFF_W-1:0]     i_holdoff,
    input  logic                     i_flush,
    output logic                     o_intr_vld,
    output logic [NR_INT-1:0]        o_intr,
    output logic                     o_busy
`ifdef VXE_INTR_SCHED_STATS_EN
    ,
    input  logic                     i_stat_clr,
    output logic [15:0]              o_stat_acc,
    output logic [15:0]              o_stat_emit
`endif
);

    localparam int PTR_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t               state_q, state_d;
    logic [NR_INT-1:0]    acc_q, acc_d;
    logic [HOLDOFF_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                 hi_any, lo_any, gnt_any;
    logic [PTR_W-1:0]     hi_idx, lo_idx, gnt_idx;
    logic [NR_INT-1:0]    sel_bits;

    // Lowest valid source at/above the pointer wins; otherwise wrap to the lowest valid overall.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int s = NR_SRC - 1; s >= 0; s--) begin
            if (i_src_vld[s]) begin
                lo_any = 1'b1;
                lo_idx = PTR_W'(s);
                if (s >= int'(rr_ptr_q)) begin
                    hi_any = 1'b1;
                    hi_idx = PTR_W'(s);
                end
            end
        end
    end

    assign gnt_idx   = hi_any ? hi_idx : lo_idx;
    assign gnt_any   = nrst && (state_q != EMIT) && (hi_any || lo_any);
    assign o_src_rdy = gnt_any ? (NR_SRC'(1) << gnt_idx) : '0;

    always_comb begin
        sel_bits = '0;
        for (int s = 0; s < NR_SRC; s++) begin
            if (gnt_idx == PTR_W'(s)) sel_bits = i_src_intr[s*NR_INT +: NR_INT];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        o_intr_vld = 1'b0;
        o_intr     = '0;

        // Grants are never issued in EMIT, so merging here cannot race the clear below.
        if (gnt_any) begin
            acc_d    = acc_q | sel_bits;
            rr_ptr_d = (gnt_idx == PTR_W'(NR_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (gnt_any && (sel_bits != '0)) begin
                    if (i_holdoff == '0) begin
                        state_d = EMIT;
                    end else begin
                        state_d = ACCUM;
                        cnt_d   = i_holdoff;
                    end
                end
            end
            ACCUM: begin
                cnt_d = cnt_q - 1'b1;
                if ((cnt_q == HOLDOFF_W'(1)) || i_flush) state_d = EMIT;
            end
            EMIT: begin
                o_intr_vld = 1'b1;
                o_intr     = acc_q;
                acc_d      = '0;
                cnt_d      = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy = (state_q != IDLE);

`ifdef VXE_INTR_SCHED_STATS_EN
    logic [15:0] stat_acc_q, stat_emit_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stat_acc_q  <= '0;
            stat_emit_q <= '0;
        end else if (i_stat_clr) begin
            stat_acc_q  <= '0;
            stat_emit_q <= '0;
        end else begin
            if (gnt_any && (stat_acc_q != 16'hFFFF))          stat_acc_q  <= stat_acc_q + 16'd1;
            if ((state_q == EMIT) && (stat_emit_q != 16'hFFFF)) stat_emit_q <= stat_emit_q + 16'd1;
        end
    end

    assign o_stat_acc  = stat_acc_q;
    assign o_stat_emit = stat_emit_q;
`endif

endmodule
